// File: rtl/serpent_iter_core.sv
// Iterative Serpent block engine (encrypt/decrypt), ROUNDS_PER_CYCLE rounds per clock.
// Optional macro SERPENT_ITER_BLKCNT_EN adds the o_blk_cnt completed-block counter.

package serpent_iter_pkg;

    // Each entry packs the 16 S-box outputs, nibble n holds S(n).
    localparam logic [63:0] SBOX [8] = '{
        64'hC90724DEB56A1F83,
        64'h43D68EB1A50972CF,
        64'h25B04E1DFAC39768,
        64'hE57A421D369C8BF0,
        64'hD7E9A4526B0C38F1,
        64'h176D8E30C9A4B25F,
        64'h0A3DF19EB6485C27,
        64'h6539AC47B28E0FD1
    };

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [3:0] sbox_lookup(input logic [2:0] sel, input logic [3:0] n);
        logic [63:0] t;
        t = SBOX[sel];
        return t[{n, 2'b00} +: 4];
    endfunction

    // Bitslice S-box layer: bit i of words 3..0 forms one nibble (word0 = LSB).
    function automatic logic [127:0] sbox_layer(input logic [2:0] sel, input logic [127:0] x,
                                                input logic inverse);
        logic [127:0] y;
        logic [3:0]   n;
        logic [3:0]   m;
        y = '0;
        for (int i = 0; i < 32; i++) begin
            n = {x[96+i], x[64+i], x[32+i], x[i]};
            m = 4'd0;
            if (inverse) begin
                for (int v = 0; v < 16; v++) begin
                    if (sbox_lookup(sel, 4'(v)) == n) m = 4'(v);
                end
            end else begin
                m = sbox_lookup(sel, n);
            end
            y[i]    = m[0];
            y[32+i] = m[1];
            y[64+i] = m[2];
            y[96+i] = m[3];
        end
        return y;
    endfunction

    function automatic logic [127:0] lt(input logic [127:0] x);
        logic [31:0] x0, x1, x2, x3;
        {x3, x2, x1, x0} = x;
        x0 = rotl(x0, 13);
        x2 = rotl(x2, 3);
        x1 = x1 ^ x0 ^ x2;
        x3 = x3 ^ x2 ^ (x0 << 3);
        x1 = rotl(x1, 1);
        x3 = rotl(x3, 7);
        x0 = x0 ^ x1 ^ x3;
        x2 = x2 ^ x3 ^ (x1 << 7);
        x0 = rotl(x0, 5);
        x2 = rotl(x2, 22);
        return {x3, x2, x1, x0};
    endfunction

    function automatic logic [127:0] lt_inv(input logic [127:0] x);
        logic [31:0] x0, x1, x2, x3;
        {x3, x2, x1, x0} = x;
        x2 = rotl(x2, 32 - 22);
        x0 = rotl(x0, 32 - 5);
        x2 = x2 ^ x3 ^ (x1 << 7);
        x0 = x0 ^ x1 ^ x3;
        x3 = rotl(x3, 32 - 7);
        x1 = rotl(x1, 32 - 1);
        x3 = x3 ^ x2 ^ (x0 << 3);
        x1 = x1 ^ x0 ^ x2;
        x2 = rotl(x2, 32 - 3);
        x0 = rotl(x0, 32 - 13);
        return {x3, x2, x1, x0};
    endfunction

endpackage

module serpent_enc_round
    import serpent_iter_pkg::*;
(
    input  logic [127:0] x,
    input  logic [127:0] k,
    input  logic [2:0]   sbox_sel,
    input  logic         last,
    output logic [127:0] y
);
    logic [127:0] s;

    always_comb begin
        s = sbox_layer(sbox_sel, x ^ k, 1'b0);
        y = last ? s : lt(s);
    end
endmodule

module serpent_dec_round
    import serpent_iter_pkg::*;
(
    input  logic [127:0] x,
    input  logic [127:0] k,
    input  logic [2:0]   sbox_sel,
    input  logic         last,
    output logic [127:0] y
);
    always_comb begin
        y = sbox_layer(sbox_sel, last ? x : lt_inv(x), 1'b1) ^ k;
    end
endmodule

module serpent_iter_core #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int NUM_ROUNDS       = 32
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic                          i_mode,
    input  logic [127:0]                  i_data,
    input  logic                          i_subkey_valid,
    output logic [5:0]                    o_key_addr,
    input  logic [128*ROUNDS_PER_CYCLE-1:0] i_key,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [127:0]                  o_data,
    output logic                          o_abort
`ifdef SERPENT_ITER_BLKCNT_EN
    ,
    output logic [31:0]                   o_blk_cnt
`endif
);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
          ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8)) begin : g_bad_rpc
        $error("serpent_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end
    if (NUM_ROUNDS != 32) begin : g_bad_rounds
        $error("serpent_iter_core: NUM_ROUNDS must be 32");
    end

    localparam logic [5:0] R6     = 6'(ROUNDS_PER_CYCLE);
    localparam logic [5:0] LAST_G = 6'(NUM_ROUNDS / ROUNDS_PER_CYCLE - 1);

    typedef enum logic [1:0] {IDLE, KEY32, RUN, DONE} state_t;

    state_t       state_q, state_d;
    logic [127:0] x_q, x_d;
    logic         mode_q, mode_d;
    logic [5:0]   g_q, g_d;
    logic         abort;
    logic [5:0]   run_addr;

    logic [127:0] enc_x [ROUNDS_PER_CYCLE+1];
    logic [127:0] dec_x [ROUNDS_PER_CYCLE+1];

    // Encrypt walks groups upward from key 0; decrypt walks them downward from key 32.
    assign run_addr = mode_q ? (6'd32 - (g_q + 6'd1) * R6) : (g_q * R6);

    assign enc_x[0] = x_q;
    assign dec_x[0] = x_q;

    // Decrypt stage j handles the highest remaining round of the group first.
    for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_stage
        logic [5:0] enc_r;
        logic [5:0] dec_r;
        assign enc_r = run_addr + 6'(j);
        assign dec_r = run_addr + 6'(ROUNDS_PER_CYCLE - 1 - j);

        serpent_enc_round u_enc (
            .x        (enc_x[j]),
            .k        (i_key[128*j +: 128]),
            .sbox_sel (enc_r[2:0]),
            .last     (enc_r == 6'd31),
            .y        (enc_x[j+1])
        );

        serpent_dec_round u_dec (
            .x        (dec_x[j]),
            .k        (i_key[128*(ROUNDS_PER_CYCLE-1-j) +: 128]),
            .sbox_sel (dec_r[2:0]),
            .last     (dec_r == 6'd31),
            .y        (dec_x[j+1])
        );
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        mode_d  = mode_q;
        g_d     = g_q;
        abort   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_valid && i_subkey_valid) begin
                    x_d     = i_data;
                    mode_d  = i_mode;
                    g_d     = 6'd0;
                    state_d = i_mode ? KEY32 : RUN;
                end
            end
            KEY32: begin
                if (!i_subkey_valid) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    x_d     = x_q ^ i_key[127:0];
                    state_d = mode_q ? RUN : DONE;
                end
            end
            RUN: begin
                if (!i_subkey_valid) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    x_d = mode_q ? dec_x[ROUNDS_PER_CYCLE] : enc_x[ROUNDS_PER_CYCLE];
                    g_d = g_q + 6'd1;
                    if (g_q == LAST_G) begin
                        g_d     = 6'd0;
                        state_d = mode_q ? DONE : KEY32;
                    end
                end
            end
            DONE: begin
                if (i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            mode_q  <= 1'b0;
            g_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            mode_q  <= mode_d;
            g_q     <= g_d;
        end
    end

    // Outputs are forced to their reset values while reset is held.
    always_comb begin
        o_ready    = 1'b0;
        o_valid    = 1'b0;
        o_data     = '0;
        o_abort    = 1'b0;
        o_key_addr = 6'd0;
        if (!i_rst) begin
            o_ready = (state_q == IDLE) && i_subkey_valid;
            o_valid = (state_q == DONE);
            o_data  = (state_q == DONE) ? x_q : '0;
            o_abort = abort;
            if (state_q == KEY32)    o_key_addr = 6'd32;
            else if (state_q == RUN) o_key_addr = run_addr;
        end
    end

`ifdef SERPENT_ITER_BLKCNT_EN
    logic [31:0] blk_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst)                             blk_cnt_q <= '0;
        else if (state_q == DONE && i_ready)   blk_cnt_q <= blk_cnt_q + 32'd1;
    end

    assign o_blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_serpent_iter_core.sv
// Self-checking bench for serpent_iter_core: one instance per legal ROUNDS_PER_CYCLE,
// checked against a whole-cipher Serpent reference model.
module tb_serpent_iter_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         mode;
    logic         skv;
    logic [127:0] din;
    logic         vin  [4];
    logic         rdy  [4];
    logic         ordy [4];
    logic         oval [4];
    logic         oab  [4];
    logic [5:0]   addr [4];
    logic [127:0] dout [4];
`ifdef SERPENT_ITER_BLKCNT_EN
    logic [31:0]  cnt  [4];
`endif

    logic [127:0] sk [33];
    int           addr_q [$];
    int           n_checks = 0;
    int           n_fail   = 0;

    localparam int EXP_LAT [4] = '{33, 17, 9, 5};

    int SB [8][16] = '{
        '{ 3,  8, 15,  1, 10,  6,  5, 11, 14, 13,  4,  2,  7,  0,  9, 12},
        '{15, 12,  2,  7,  9,  0,  5, 10,  1, 11, 14,  8,  6, 13,  3,  4},
        '{ 8,  6,  7,  9,  3, 12, 10, 15, 13,  1, 14,  4,  0, 11,  5,  2},
        '{ 0, 15, 11,  8, 12,  9,  6,  3, 13,  1,  2,  4, 10,  7,  5, 14},
        '{ 1, 15,  8,  3, 12,  0, 11,  6,  2,  5,  4, 10,  9, 14,  7, 13},
        '{15,  5,  2, 11,  4, 10,  9, 12,  0,  3, 14,  8, 13,  6,  7,  1},
        '{ 7,  2, 12,  5,  8,  4,  6, 11, 14,  9,  1, 15, 13,  3, 10,  0},
        '{ 1, 13, 15,  0, 14,  8,  2, 11,  7,  4, 12, 10,  9,  3,  5,  6}
    };
    int SBI [8][16];

    // One DUT per unroll factor, each with its own key-store read port.
    for (genvar d = 0; d < 4; d++) begin : g_dut
        localparam int RR = 1 << d;
        logic [128*RR-1:0] key_bus;

        always_comb begin
            key_bus = '0;
            for (int j = 0; j < RR; j++) begin
                if (int'(addr[d]) + j <= 32) key_bus[128*j +: 128] = sk[int'(addr[d]) + j];
            end
        end

        serpent_iter_core #(.ROUNDS_PER_CYCLE(RR)) u_dut (
            .i_clk          (clk),
            .i_rst          (rst),
            .i_valid        (vin[d]),
            .o_ready        (ordy[d]),
            .i_mode         (mode),
            .i_data         (din),
            .i_subkey_valid (skv),
            .o_key_addr     (addr[d]),
            .i_key          (key_bus),
            .o_valid        (oval[d]),
            .i_ready        (rdy[d]),
            .o_data         (dout[d]),
            .o_abort        (oab[d])
`ifdef SERPENT_ITER_BLKCNT_EN
            ,
            .o_blk_cnt      (cnt[d])
`endif
        );
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] rol(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] m_sbox(input int s, input logic [127:0] x, input bit inv);
        logic [127:0] y;
        int nib, o;
        y = '0;
        for (int i = 0; i < 32; i++) begin
            nib = int'(x[i]) + 2 * int'(x[32+i]) + 4 * int'(x[64+i]) + 8 * int'(x[96+i]);
            o = inv ? SBI[s][nib] : SB[s][nib];
            y[i]    = o[0];
            y[32+i] = o[1];
            y[64+i] = o[2];
            y[96+i] = o[3];
        end
        return y;
    endfunction

    function automatic logic [127:0] m_lt(input logic [127:0] x, input bit inv);
        logic [31:0] w [4];
        for (int i = 0; i < 4; i++) w[i] = x[32*i +: 32];
        if (!inv) begin
            w[0] = rol(w[0], 13);  w[2] = rol(w[2], 3);
            w[1] = w[1] ^ w[0] ^ w[2];  w[3] = w[3] ^ w[2] ^ (w[0] << 3);
            w[1] = rol(w[1], 1);   w[3] = rol(w[3], 7);
            w[0] = w[0] ^ w[1] ^ w[3];  w[2] = w[2] ^ w[3] ^ (w[1] << 7);
            w[0] = rol(w[0], 5);   w[2] = rol(w[2], 22);
        end else begin
            w[2] = rol(w[2], 10);  w[0] = rol(w[0], 27);
            w[2] = w[2] ^ w[3] ^ (w[1] << 7);  w[0] = w[0] ^ w[1] ^ w[3];
            w[3] = rol(w[3], 25);  w[1] = rol(w[1], 31);
            w[3] = w[3] ^ w[2] ^ (w[0] << 3);  w[1] = w[1] ^ w[0] ^ w[2];
            w[2] = rol(w[2], 29);  w[0] = rol(w[0], 19);
        end
        return {w[3], w[2], w[1], w[0]};
    endfunction

    function automatic logic [127:0] model_enc(input logic [127:0] pt);
        logic [127:0] x = pt;
        for (int r = 0; r < 32; r++) begin
            x = m_sbox(r % 8, x ^ sk[r], 1'b0);
            if (r != 31) x = m_lt(x, 1'b0);
        end
        return x ^ sk[32];
    endfunction

    function automatic logic [127:0] model_dec(input logic [127:0] ct);
        logic [127:0] x = ct ^ sk[32];
        for (int r = 31; r >= 0; r--) begin
            if (r != 31) x = m_lt(x, 1'b1);
            x = m_sbox(r % 8, x, 1'b1) ^ sk[r];
        end
        return x;
    endfunction

    function automatic int exp_addr(input int rr, input bit m, input int i);
        int groups = 32 / rr;
        if (m) begin
            if (i == 0)      return 32;
            if (i <= groups) return 32 - i * rr;
            return 0;
        end
        if (i < groups)  return i * rr;
        if (i == groups) return 32;
        return 0;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- checking / stimulus tasks ----------------
    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int d, input logic m, input logic [127:0] blk,
                                 output logic [127:0] res, output int lat);
        int waited;
        res = '0;
        lat = -1;
        @(negedge clk);
        din = blk; mode = m; vin[d] = 1'b1;
        #1;
        waited = 0;
        while (!ordy[d] && waited < 50) begin
            @(negedge clk); #1; waited++;
        end
        if (!ordy[d]) begin
            vin[d] = 1'b0;
            checkOutput("accept_timeout", 128'd0, 128'd1);
            return;
        end
        @(posedge clk);
        @(negedge clk);
        vin[d] = 1'b0; din = ~blk; mode = ~m;
        #1;
        addr_q.delete();
        lat = 0;
        while (1) begin
            addr_q.push_back(int'(addr[d]));
            if (oval[d] || lat >= 100) break;
            @(negedge clk); #1; lat++;
        end
        if (!oval[d]) begin
            checkOutput("valid_timeout", 128'd0, 128'd1);
            return;
        end
        res = dout[d];
        rdy[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rdy[d] = 1'b0;
        #1;
        checkOutput("ready_after_done", 128'(ordy[d]), 128'd1);
        checkOutput("valid_after_done", 128'(oval[d]), 128'd0);
    endtask

    task automatic check_trace(input int d, input bit m, input int lat);
        int errs = 0;
        if (addr_q.size() != lat + 1) errs++;
        foreach (addr_q[i]) if (addr_q[i] != exp_addr(1 << d, m, i)) errs++;
        checkOutput($sformatf("key_addr_trace_d%0d_m%0d", d, m), 128'(errs), 128'd0);
    endtask

    typedef struct {
        int           d;
        logic         m;
        logic [127:0] din;
        logic [127:0] exp;
        int           exp_lat;
    } vec_t;

    vec_t         vecs [12];
    logic [127:0] res, held, blk;
    int           lat, waited, seen;

    localparam logic [127:0] PT = 128'h0123456789ABCDEF_FEDCBA9876543210;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int s = 0; s < 8; s++)
            for (int v = 0; v < 16; v++) SBI[s][SB[s][v]] = v;
        for (int d = 0; d < 4; d++) begin vin[d] = 1'b0; rdy[d] = 1'b0; end
        for (int k = 0; k < 33; k++) sk[k] = '0;
        rst = 1'b1; skv = 1'b1; mode = 1'b0; din = '0;

        // Reset state: outputs at reset values while reset is held, even with keys present.
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            checkOutput($sformatf("rst_ready_d%0d", d), 128'(ordy[d]), 128'd0);
            checkOutput($sformatf("rst_valid_d%0d", d), 128'(oval[d]), 128'd0);
            checkOutput($sformatf("rst_data_d%0d", d), dout[d], 128'd0);
            checkOutput($sformatf("rst_abort_d%0d", d), 128'(oab[d]), 128'd0);
            checkOutput($sformatf("rst_addr_d%0d", d), 128'(addr[d]), 128'd0);
        end
        rst = 1'b0;
        @(negedge clk); #1;
        checkOutput("ready_after_reset", 128'(ordy[0]), 128'd1);

        // All-zero schedule, zero block, one round per cycle.
        applyStimulus(0, 1'b0, 128'd0, res, lat);
        checkOutput("zero_sched_data", res, model_enc(128'd0));
        checkOutput("zero_sched_lat", 128'(lat), 128'd33);
        check_trace(0, 1'b0, lat);

        for (int k = 0; k < 33; k++) sk[k] = rand128();

        // Vector table: round trip of the fixed block for every R, then random blocks.
        for (int d = 0; d < 4; d++) begin
            vecs[2*d]   = '{d, 1'b0, PT, model_enc(PT), EXP_LAT[d]};
            vecs[2*d+1] = '{d, 1'b1, model_enc(PT), PT, EXP_LAT[d]};
        end
        for (int k = 0; k < 4; k++) begin
            blk = rand128();
            vecs[8+k] = '{k, k[0], blk, k[0] ? model_dec(blk) : model_enc(blk), EXP_LAT[k]};
        end
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].d, vecs[i].m, vecs[i].din, res, lat);
            checkOutput($sformatf("vec%0d_data", i), res, vecs[i].exp);
            checkOutput($sformatf("vec%0d_lat", i), 128'(lat), 128'(vecs[i].exp_lat));
            check_trace(vecs[i].d, vecs[i].m, lat);
        end

        // Randomised blocks against the model.
        for (int i = 0; i < 8; i++) begin
            int  d;
            bit  m;
            d   = $urandom_range(0, 3);
            m   = 1'($urandom_range(0, 1));
            blk = rand128();
            applyStimulus(d, m, blk, res, lat);
            checkOutput($sformatf("rand%0d_data", i), res, m ? model_dec(blk) : model_enc(blk));
            checkOutput($sformatf("rand%0d_lat", i), 128'(lat), 128'(EXP_LAT[d]));
        end

        // Subkey loss at RUN cycle 5 aborts the block.
        @(negedge clk);
        din = rand128(); mode = 1'b0; vin[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vin[0] = 1'b0;
        repeat (5) @(negedge clk);
        skv = 1'b0;
        #1;
        checkOutput("abort_pulse", 128'(oab[0]), 128'd1);
        checkOutput("abort_no_valid", 128'(oval[0]), 128'd0);
        @(negedge clk);
        skv = 1'b1;
        #1;
        checkOutput("abort_single_cycle", 128'(oab[0]), 128'd0);
        checkOutput("abort_ready_next", 128'(ordy[0]), 128'd1);
        checkOutput("abort_valid_low", 128'(oval[0]), 128'd0);
        blk = rand128();
        applyStimulus(0, 1'b0, blk, res, lat);
        checkOutput("post_abort_data", res, model_enc(blk));

        // Result held in DONE while downstream stalls; new requests are refused.
        blk = rand128();
        @(negedge clk);
        din = blk; mode = 1'b1; vin[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vin[1] = 1'b0;
        #1;
        waited = 0;
        while (!oval[1] && waited < 50) begin @(negedge clk); #1; waited++; end
        checkOutput("hold_valid_reached", 128'(oval[1]), 128'd1);
        for (int c = 0; c < 10; c++) begin
            vin[1] = 1'b1; din = rand128(); mode = 1'b0;
            @(negedge clk); #1;
            checkOutput($sformatf("hold_valid_c%0d", c), 128'(oval[1]), 128'd1);
            checkOutput($sformatf("hold_data_c%0d", c), dout[1], model_dec(blk));
            checkOutput($sformatf("hold_ready_c%0d", c), 128'(ordy[1]), 128'd0);
        end
        vin[1] = 1'b0; rdy[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rdy[1] = 1'b0;
        #1;
        checkOutput("hold_release_valid", 128'(oval[1]), 128'd0);
        checkOutput("hold_release_ready", 128'(ordy[1]), 128'd1);

        // Reset in the middle of RUN discards the block silently.
        @(negedge clk);
        din = rand128(); mode = 1'b0; vin[3] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vin[3] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        checkOutput("midrst_ready", 128'(ordy[3]), 128'd0);
        checkOutput("midrst_valid", 128'(oval[3]), 128'd0);
        checkOutput("midrst_data", dout[3], 128'd0);
        checkOutput("midrst_abort", 128'(oab[3]), 128'd0);
        checkOutput("midrst_addr", 128'(addr[3]), 128'd0);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); #1;
            if (oval[3] || oab[3]) seen++;
        end
        checkOutput("midrst_no_result", 128'(seen), 128'd0);
        checkOutput("midrst_ready_after", 128'(ordy[3]), 128'd1);

`ifdef SERPENT_ITER_BLKCNT_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("blkcnt_cleared", 128'(cnt[3]), 128'd0);
        for (int i = 0; i < 3; i++) begin
            blk = rand128();
            applyStimulus(3, 1'b0, blk, res, lat);
        end
        checkOutput("blkcnt_three", 128'(cnt[3]), 128'd3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("blkcnt_reset", 128'(cnt[3]), 128'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serpent_iter_core.md
Name: serpent_iter_core

Overview:
- Parametrised iterative Serpent block engine that performs both encryption and decryption on 128-bit blocks.
- Computes ROUNDS_PER_CYCLE rounds per clock by instantiating the existing per-round encrypt and decrypt stage modules that many times.
- Reads subkeys from the external key-schedule store through an address/data port.
- Sits between the XTS tweak/data path and the key store, with valid/ready handshakes on input and output.

Parameters:
- ROUNDS_PER_CYCLE, 1, rounds unrolled per clock. Legal values: 1, 2, 4, 8. Any other value is an elaboration error.
- NUM_ROUNDS, 32, Serpent round count. Fixed at 32 and not overridden.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  input block valid.
- o_ready  output  1  core can accept a block.
- i_mode  input  1  0 = encrypt, 1 = decrypt. Sampled on accept.
- i_data  input  128  input block. Word0 = [31:0].
- i_subkey_valid  input  1  key store holds a complete schedule.
- o_key_addr  output  6  lowest subkey index requested this cycle.
- i_key  input  128*ROUNDS_PER_CYCLE  lane j = subkey (o_key_addr+j), combinational same-cycle read.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.
- o_data  output  128  result block.
- o_abort  output  1  one-cycle pulse: operation aborted.

Behaviour:
- Reset values: o_ready=0 while i_rst is high, o_valid=0, o_data=0, o_abort=0, o_key_addr=0. State goes to IDLE.
- Reset mid-operation discards the block with no o_valid and no o_abort.
- States: IDLE, KEY32, RUN, DONE.
- IDLE:
  - o_ready = i_subkey_valid.
  - Accept on i_valid & o_ready: latch i_data and i_mode, clear the group counter g.
  - Next state: KEY32 if decrypting, RUN if encrypting.
- KEY32:
  - o_key_addr=32; X ^= lane0.
  - Next state: RUN if decrypting, DONE if encrypting.
- RUN, G = 32/ROUNDS_PER_CYCLE groups, g = 0..G-1:
  - Encrypt: o_key_addr = g*R. Apply rounds r = g*R .. g*R+R-1 in ascending order, each X = LT(S_r(X ^ K_r)).
  - Encrypt, r=31: LT is omitted and KEY32 follows.
  - Decrypt: o_key_addr = 32-(g+1)*R. Apply rounds from highest to lowest, each X = S_r^-1(LTinv(X)) ^ K_r.
  - Decrypt, r=31: LTinv is omitted.
  - The S-box index is r mod 8 in both directions.
  - Last group: next state is DONE if decrypting, KEY32 if encrypting.
- DONE:
  - o_valid=1 and o_data=X, held stable until i_ready.
  - On o_valid & i_ready, go to IDLE. o_ready rises the following cycle; there is no same-cycle re-accept.
- Latency:
  - o_valid asserts exactly 32/R+1 clock edges after the accepting edge: R=1 → 33, R=2 → 17, R=4 → 9, R=8 → 5.
  - Throughput is one block per 32/R+3 cycles when i_ready is held high.
- Subkey loss: i_subkey_valid low in KEY32 or RUN → o_abort pulses 1 cycle, state goes to IDLE, o_valid stays 0.
  - In DONE, i_subkey_valid is ignored and the result is kept.
- i_valid held while busy: o_ready=0 and no capture. i_data/i_mode changes after accept have no effect.
- o_key_addr in IDLE and DONE is 0. Lanes indexing above 32 are don't-care.
- All arithmetic on g and o_key_addr is 6-bit unsigned with no wrap in legal configurations.

Optional Feature:
- Macro SERPENT_ITER_BLKCNT_EN.
- Defined: adds output o_blk_cnt [31:0].
  - Increments on each o_valid & i_ready handshake and wraps 0xFFFFFFFF → 0.
  - Cleared by i_rst. Not incremented on abort.
- Undefined: no port, no counter logic. All other behaviour is identical.

Test Plan:
- All-zero schedule, encrypt, i_data=0, R=1 → o_valid 33 edges after accept; o_data equals the team's C model output for the same schedule.
- Encrypt then decrypt 128'h0123456789ABCDEF_FEDCBA9876543210 with a random schedule, for each R ∈ {1,2,4,8} → decrypt returns the original block; latencies are 33/17/9/5.
- Decrypt R=4 → o_key_addr sequence is 32, 28, 24, …, 0 (9 cycles), then 0 in DONE.
- i_subkey_valid dropped at RUN cycle 5 → o_abort single pulse, o_valid never rises, o_ready=1 next cycle, and a fresh block completes correctly.
- i_ready held low 10 cycles in DONE → o_valid and o_data stable throughout; i_valid asserted meanwhile is not accepted.
- i_rst asserted mid-RUN → next cycle all outputs are at reset values. With SERPENT_ITER_BLKCNT_EN, 3 completed blocks give o_blk_cnt=3, and reset clears it to 0.
